// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    // XOR of the low nbits of d (even-parity bit of the sent data bits).
    function automatic logic data_parity(input logic [7:0] d, input int nbits);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) p ^= d[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// FIFO-side handshake between the transmit FIFO and the tx sequencer.
// Latency: none (plain wires); fifo_data is combinational from the FIFO head.
// Backpressure: the sequencer pops only when fifo_empty is low.
//   master : sequencer side (drives fifo_pop)
//   slave  : FIFO side (drives fifo_data, fifo_empty)
interface uart_tx_ctrl_if;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_pop;

    modport master (input fifo_data, input fifo_empty, output fifo_pop);
    modport slave  (output fifo_data, output fifo_empty, input fifo_pop);
endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter producing one bit_done pulse per bit period of div cycles.
// Latency: bit_done_o on the div-th cycle after load_i (load cycle not counted).
// Backpressure: none; load_i wins over counting, counting only while en_i.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : restart a bit period and capture div_i (must be >= 1)
//   en_i       : count enable (frame in progress)
//   div_i      : cycles per bit
//   bit_done_o : last cycle of the current bit period
module uart_baud_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             bit_done_o
);
    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] per_q, per_d;

    assign bit_done_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        per_d = per_q;
        if (load_i) begin
            cnt_d = div_i - ONE;
            per_d = div_i;
        end else if (en_i) begin
            // Auto-reload so consecutive bits need no explicit load.
            cnt_d = bit_done_o ? (per_q - ONE) : (cnt_q - ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            per_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
        end
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART tx sequencer: pops the FIFO head and serialises start/data(LSB first)/[parity]/stop.
// Latency: tx falls 1 cycle after the pop cycle; frame = (1+DATA_BITS+P+STOP_BITS)*div cycles.
// Backpressure: pops only when tx_en && !fifo_empty, in IDLE or the last stop cycle (back-to-back).
//   clk, reset   : clock, synchronous active-high reset (aborts a frame immediately)
//   tx_en        : allow new frames to start
//   baud_div     : cycles per bit (0 treated as 1), sampled at frame start
//   fif          : FIFO handshake (fifo_data, fifo_empty in; fifo_pop out)
//   tx, busy     : serial line (idle high), frame-in-progress flag
//   parity_odd, parity_sel : only when UART_TX_PARITY_EN is defined; latched at frame start
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_en,
`ifdef UART_TX_PARITY_EN
    input  logic             parity_odd,
    input  logic             parity_sel,
`endif
    input  logic [DIV_W-1:0] baud_div,
    uart_tx_ctrl_if.master   fif,
    output logic             tx,
    output logic             busy
);
    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);
    localparam logic [BCW-1:0] BC_ONE    = {{(BCW-1){1'b0}}, 1'b1};

    tx_state_t        state_q;
    logic [7:0]       shift_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic             tx_q;
    logic             busy_q;
`ifdef UART_TX_PARITY_EN
    logic             par_en_q;
    logic             par_bit_q;
`endif

    logic             bit_done;
    logic             frame_end;
    logic             pop;
    logic [DIV_W-1:0] div_eff;

    assign div_eff   = (baud_div == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : baud_div;
    assign frame_end = (state_q == STOP) && bit_done && (bit_cnt_q == LAST_STOP);

    // Pop is combinational so the byte is taken in the same cycle the FIFO
    // shows it non-empty; reset suppresses it so an aborted cycle loses no data.
    assign pop = !reset && tx_en && !fif.fifo_empty &&
                 ((state_q == IDLE) || frame_end);

    assign fif.fifo_pop = pop;
    assign tx           = tx_q;
    assign busy         = busy_q;

    uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
        .clk       (clk),
        .reset     (reset),
        .load_i    (pop),
        .en_i      (state_q != IDLE),
        .div_i     (div_eff),
        .bit_done_o(bit_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= UART_IDLE_LVL;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else if (pop) begin
            // Frame start, from IDLE or straight out of the last stop cycle.
            state_q   <= START;
            shift_q   <= fif.fifo_data;
            bit_cnt_q <= '0;
            tx_q      <= UART_START_LVL;
            busy_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= parity_sel;
            par_bit_q <= data_parity(fif.fifo_data, DATA_BITS) ^ parity_odd;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= UART_IDLE_LVL;
                    busy_q <= 1'b0;
                end
                START: if (bit_done) begin
                    state_q <= DATA;
                    tx_q    <= shift_q[0];
                end
                DATA: if (bit_done) begin
                    shift_q <= {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_q <= PARITY;
                            tx_q    <= par_bit_q;
                        end else begin
                            state_q <= STOP;
                            tx_q    <= UART_IDLE_LVL;
                        end
`else
                        state_q <= STOP;
                        tx_q    <= UART_IDLE_LVL;
`endif
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BC_ONE;
                        tx_q      <= shift_q[1];
                    end
                end
                PARITY: if (bit_done) begin
                    state_q <= STOP;
                    tx_q    <= UART_IDLE_LVL;
                end
                STOP: if (bit_done) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_q   <= IDLE;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BC_ONE;
                    end
                    tx_q <= UART_IDLE_LVL;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= UART_IDLE_LVL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: byte-queue FIFO model, expected-frame scoreboard, tx monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_ctrl;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] bits;   // bit 0 = start bit, sent first
        int          nbits;
        int          div;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        tx_en;
    logic [15:0] baud_div;
    logic        tx;
    logic        busy;
    logic        parity_odd;
    logic        parity_sel;

    uart_tx_ctrl_if fif();

    uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(1), .DIV_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_en     (tx_en),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
        .parity_sel(parity_sel),
`endif
        .baud_div  (baud_div),
        .fif       (fif),
        .tx        (tx),
        .busy      (busy)
    );

    logic [7:0] fq[$];
    exp_t       expq[$];
    int         vectors     = 0;
    int         miscompares = 0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO model: pop decided from the stable mid-cycle strobe, applied just after the edge.
    initial begin : fifo_model
        logic       p;
        logic [7:0] tmp;
        fif.fifo_data  = 8'h00;
        fif.fifo_empty = 1'b1;
        forever begin
            @(negedge clk);
            p = fif.fifo_pop;
            @(posedge clk);
            #1;
            if (p === 1'b1 && fq.size() > 0) tmp = fq.pop_front();
            fif.fifo_empty = (fq.size() == 0);
            fif.fifo_data  = (fq.size() > 0) ? fq[0] : 8'h00;
        end
    end

    // Monitor: on each pop, take the next expected frame and check every bit period.
    initial begin : monitor
        exp_t e;
        logic pend;
        logic lastpop;
        logic ok;
        logic abort;
        pend = 1'b0;
        forever begin
            if (!pend) @(negedge clk);
            pend = 1'b0;
            if (fif.fifo_pop === 1'b1) begin
                if (expq.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    e       = expq.pop_front();
                    abort   = 1'b0;
                    lastpop = 1'b0;
                    for (int b = 0; b < e.nbits && !abort; b++) begin
                        ok = 1'b1;
                        for (int c = 0; c < e.div && !abort; c++) begin
                            @(negedge clk);
                            if (reset) begin
                                abort = 1'b1;
                            end else begin
                                if (tx !== e.bits[b]) ok = 1'b0;
                                if (busy !== 1'b1) ok = 1'b0;
                                lastpop = fif.fifo_pop;
                                if (lastpop && !(b == e.nbits - 1 && c == e.div - 1)) ok = 1'b0;
                            end
                        end
                        if (!abort) check($sformatf("frame_%02h_bit%0d_ok", e.data, b), int'(ok), 1);
                    end
                    pend = !abort && lastpop;
                end
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic [15:0] bits, input int nb, input int dv);
        fq.push_back(d);
        expq.push_back('{d, bits, nb, dv});
    endtask

    task automatic add_exp(input logic [7:0] d, input logic [15:0] bits, input int nb, input int dv);
        expq.push_back('{d, bits, nb, dv});
    endtask

    // Observe n cycles: pops, cycles between first two pops, busy cycles, tx-low cycles.
    task automatic run_count(input int n, output int pops, output int gap,
                             output int busyc, output int txlow);
        int last;
        last  = -1;
        pops  = 0;
        gap   = -1;
        busyc = 0;
        txlow = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (fif.fifo_pop === 1'b1) begin
                if (pops == 1) gap = i - last;
                last = i;
                pops++;
            end
            if (busy === 1'b1) busyc++;
            if (tx !== 1'b1) txlow++;
        end
    endtask

    task automatic wait_pop(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (fif.fifo_pop !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) check("wait_pop_timeout", 1, 0);
    endtask

    initial begin : stim
        int pops, gap, busyc, txlow;
        reset      = 1'b1;
        tx_en      = 1'b0;
        baud_div   = 16'd4;
        parity_odd = 1'b0;
        parity_sel = 1'b0;

        @(posedge clk);
        @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_pop", int'(fif.fifo_pop), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        tx_en = 1'b1;

        // 1: single 0x55 frame at div 4.
        push(8'h55, 16'b1_01010101_0, 10, 4);
        run_count(60, pops, gap, busyc, txlow);
        check("t1_pops", pops, 1);
        check("t1_busy_cycles", busyc, 40);
        check("t1_tx_low_cycles", txlow, 20);

        // 2: two queued bytes go out back to back.
        @(posedge clk);
        #2;
        push(8'hA3, 16'b1_10100011_0, 10, 4);
        push(8'h0F, 16'b1_00001111_0, 10, 4);
        run_count(120, pops, gap, busyc, txlow);
        check("t2_pops", pops, 2);
        check("t2_pop_gap", gap, 40);
        check("t2_busy_cycles", busyc, 80);

        // 3: empty FIFO stays idle.
        run_count(100, pops, gap, busyc, txlow);
        check("t3_pops", pops, 0);
        check("t3_busy_cycles", busyc, 0);
        check("t3_tx_low_cycles", txlow, 0);

        // 4: tx_en dropped during DATA of frame 1, second byte must wait.
        @(posedge clk);
        #2;
        push(8'h3C, 16'b1_00111100_0, 10, 4);
        fq.push_back(8'hC3);
        fork
            run_count(80, pops, gap, busyc, txlow);
            begin
                repeat (12) @(posedge clk);
                #2 tx_en = 1'b0;
            end
        join
        check("t4_pops", pops, 1);
        check("t4_busy_cycles", busyc, 40);
        check("t4_fifo_left", fq.size(), 1);
        check("t4_idle_busy", int'(busy), 0);
        @(posedge clk);
        #2;
        add_exp(8'hC3, 16'b1_11000011_0, 10, 4);
        tx_en = 1'b1;
        run_count(60, pops, gap, busyc, txlow);
        check("t4_resume_pops", pops, 1);
        check("t4_resume_busy", busyc, 40);

        // 5: reset 10 cycles into a frame aborts it; next byte goes normally.
        @(posedge clk);
        #2;
        push(8'h96, 16'b1_10010110_0, 10, 4);
        push(8'h81, 16'b1_10000001_0, 10, 4);
        wait_pop(20);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_reset_tx", int'(tx), 1);
        check("t5_reset_busy", int'(busy), 0);
        check("t5_reset_pop", int'(fif.fifo_pop), 0);
        @(posedge clk);
        @(negedge clk);
        check("t5_reset_hold_pop", int'(fif.fifo_pop), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        run_count(60, pops, gap, busyc, txlow);
        check("t5_after_pops", pops, 1);
        check("t5_after_busy", busyc, 40);

        // 6: baud_div 0 means one cycle per bit.
        @(posedge clk);
        #2;
        baud_div = 16'd0;
`ifdef UART_TX_PARITY_EN
        parity_sel = 1'b1;
        parity_odd = 1'b1;
        push(8'h07, 16'b1_0_00000111_0, 11, 1);
        run_count(30, pops, gap, busyc, txlow);
        check("t6_pops", pops, 1);
        check("t6_busy_cycles", busyc, 11);
        parity_sel = 1'b0;
`else
        push(8'h07, 16'b1_00000111_0, 10, 1);
        run_count(30, pops, gap, busyc, txlow);
        check("t6_pops", pops, 1);
        check("t6_busy_cycles", busyc, 10);
`endif

        check("leftover_expect", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
